alu_add_logic: RTL and testbench

Registered 32-bit arithmetic/logic slice providing the ADD, AND and NOR operations of the MIPS datapath ALU. It accepts two operands and a 4-bit ALU control code, computes the selected function, and presents the result with a zero flag and optional carry/overflow flags one clock later. It sits between the register-file/immediate mux and the ALU result mux, alongside the SUB/SLT/SLL slices.

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_add_logic_adder_32bit.sv | 15 +
 rtl/alu_add_logic.sv | 111 +++++++++++
 tb/tb_alu_add_logic.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control codes and helpers, reused by every ALU slice of the MIPS datapath.
package alu_pkg;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t ALU_AND = 4'b0000;
    localparam alu_op_t ALU_ADD = 4'b0010;
    localparam alu_op_t ALU_SUB = 4'b0110;
    localparam alu_op_t ALU_SLT = 4'b0111;
    localparam alu_op_t ALU_NOR = 4'b1100;
    localparam alu_op_t ALU_SLL = 4'b1110;

    // Signed overflow of a two's-complement add, from the operand and sum sign bits.
    function automatic logic add_overflow(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/alu_add_logic_adder_32bit.sv
// Combinational 32-bit adder producing the sum and the carry-out.
module adder_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum,
    output logic        cout
);

    logic [32:0] sum_ext_s;

    assign sum_ext_s = {1'b0, a} + {1'b0, b};
    assign sum       = sum_ext_s[31:0];
    assign cout      = sum_ext_s[32];

endmodule

// File: rtl/alu_add_logic.sv
// Registered ADD/AND/NOR ALU slice with zero/illegal flags and one-cycle latency.
// Define ALU_FLAGS_EN to add the carry and overflow output ports.
module alu_add_logic
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
`ifdef ALU_FLAGS_EN
    output logic             illegal,
    output logic             carry,
    output logic             overflow
`else
    output logic             illegal
`endif
);

    logic [WIDTH-1:0] sum_s;
    logic             carry_s;
    logic [WIDTH-1:0] result_s;
    logic             illegal_s;
    logic             is_add_s;

    logic             out_valid_r;
    logic [WIDTH-1:0] result_r;
    logic             zero_r;
    logic             illegal_r;

    adder_32bit u_adder (
        .a    (rs),
        .b    (rt),
        .sum  (sum_s),
        .cout (carry_s)
    );

    // Select the function result; unsupported codes yield zero and flag illegal.
    always_comb begin
        result_s  = {WIDTH{1'b0}};
        illegal_s = 1'b0;
        is_add_s  = 1'b0;
        case (op)
            ALU_ADD: begin
                result_s = sum_s;
                is_add_s = 1'b1;
            end
            ALU_AND: result_s = rs & rt;
            ALU_NOR: result_s = ~(rs | rt);
            default: illegal_s = 1'b1;
        endcase
    end

    // Output registers: valid pulses per accepted input, data holds when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            result_r    <= {WIDTH{1'b0}};
            zero_r      <= 1'b0;
            illegal_r   <= 1'b0;
        end else begin
            out_valid_r <= in_valid;
            if (in_valid) begin
                result_r  <= result_s;
                zero_r    <= (result_s == {WIDTH{1'b0}});
                illegal_r <= illegal_s;
            end else begin
                result_r  <= result_r;
                zero_r    <= zero_r;
                illegal_r <= illegal_r;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign zero      = zero_r;
    assign illegal   = illegal_r;

`ifdef ALU_FLAGS_EN
    logic carry_r;
    logic overflow_r;

    // Carry/overflow registers, meaningful only for ADD and cleared otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else if (in_valid) begin
            carry_r    <= is_add_s & carry_s;
            overflow_r <= is_add_s & add_overflow(rs[WIDTH-1], rt[WIDTH-1], sum_s[WIDTH-1]);
        end else begin
            carry_r    <= carry_r;
            overflow_r <= overflow_r;
        end
    end

    assign carry    = carry_r;
    assign overflow = overflow_r;
`else
    logic unused_flags_s;
    assign unused_flags_s = carry_s ^ is_add_s;
`endif

endmodule

// File: tb/tb_alu_add_logic.sv
// Self-checking bench for alu_add_logic: directed corner cases plus random ops against a reference model.
module tb_alu_add_logic;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  op = 4'b0000;
    logic [31:0] rs = 32'h0;
    logic [31:0] rt = 32'h0;
    logic        out_valid;
    logic [31:0] result;
    logic        zero;
    logic        illegal;
`ifdef ALU_FLAGS_EN
    logic        carry;
    logic        overflow;
`endif

    int checks = 0;
    int failures = 0;

    logic        exp_valid = 1'b0;
    logic [31:0] exp_result = 32'h0;
    logic        exp_zero = 1'b0;
    logic        exp_illegal = 1'b0;
    logic        exp_carry = 1'b0;
    logic        exp_overflow = 1'b0;

    alu_add_logic #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .op        (op),
        .rs        (rs),
        .rt        (rt),
        .out_valid (out_valid),
        .result    (result),
        .zero      (zero),
`ifdef ALU_FLAGS_EN
        .illegal   (illegal),
        .carry     (carry),
        .overflow  (overflow)
`else
        .illegal   (illegal)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operation definitions.
    task automatic model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        longint usum;
        longint ssum;
        exp_carry = 1'b0;
        exp_overflow = 1'b0;
        exp_illegal = 1'b0;
        if (o == 4'b0010) begin
            usum = longint'({32'h0, a}) + longint'({32'h0, b});
            ssum = longint'($signed(a)) + longint'($signed(b));
            exp_result = usum[31:0];
            exp_carry = (usum >= 64'sh1_0000_0000);
            exp_overflow = (ssum > 64'sd2147483647) || (ssum < -64'sd2147483648);
        end else if (o == 4'b0000) begin
            exp_result = a & b;
        end else if (o == 4'b1100) begin
            exp_result = ~(a | b);
        end else begin
            exp_result = 32'h0;
            exp_illegal = 1'b1;
        end
        exp_zero = (exp_result == 32'h0);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".out_valid"}, {31'h0, out_valid}, {31'h0, exp_valid});
        chk({tag, ".result"}, result, exp_result);
        chk({tag, ".zero"}, {31'h0, zero}, {31'h0, exp_zero});
        chk({tag, ".illegal"}, {31'h0, illegal}, {31'h0, exp_illegal});
`ifdef ALU_FLAGS_EN
        chk({tag, ".carry"}, {31'h0, carry}, {31'h0, exp_carry});
        chk({tag, ".overflow"}, {31'h0, overflow}, {31'h0, exp_overflow});
`endif
    endtask

    task automatic step(input string tag, input logic v, input logic [3:0] o,
                        input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        in_valid = v;
        op = o;
        rs = a;
        rt = b;
        @(posedge clk);
        #1;
        if (v) model(o, a, b);
        exp_valid = v;
        check_all(tag);
    endtask

    task automatic clear_model();
        exp_valid = 1'b0;
        exp_result = 32'h0;
        exp_zero = 1'b0;
        exp_illegal = 1'b0;
        exp_carry = 1'b0;
        exp_overflow = 1'b0;
    endtask

    initial begin
        logic [3:0] ops [5];
        logic [3:0] rop;
        ops[0] = 4'b0010;
        ops[1] = 4'b0000;
        ops[2] = 4'b1100;
        ops[3] = 4'b0110;
        ops[4] = 4'b1111;

        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        step("add_ovf", 1'b1, 4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
        chk("add_ovf.lit", result, 32'h8000_0000);
        step("add_wrap", 1'b1, 4'b0010, 32'hFFFF_FFFF, 32'h0000_0001);
        chk("add_wrap.zero_lit", {31'h0, zero}, 32'h1);
        step("and", 1'b1, 4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00);
        chk("and.lit", result, 32'hF000_F000);
        step("nor", 1'b1, 4'b1100, 32'h0, 32'h0);
        chk("nor.lit", result, 32'hFFFF_FFFF);
        step("illegal", 1'b1, 4'b0110, 32'h5, 32'h3);
        chk("illegal.lit", {31'h0, illegal}, 32'h1);

        step("b2b_add", 1'b1, 4'b0010, 32'h1234_5678, 32'h1111_1111);
        step("b2b_and", 1'b1, 4'b0000, 32'hAAAA_5555, 32'h0F0F_F0F0);
        step("b2b_nor", 1'b1, 4'b1100, 32'h0000_FFFF, 32'h00FF_0000);
        step("idle_hold", 1'b0, 4'b0010, 32'hDEAD_BEEF, 32'h1);
        chk("idle_hold.lit", result, 32'hFF00_0000);
        step("idle_hold2", 1'b0, 4'b0000, 32'h0, 32'h0);

        // Reset asserted mid-cycle while a valid transfer is presented.
        step("pre_rst", 1'b1, 4'b0010, 32'h0000_0010, 32'h0000_0020);
        @(negedge clk);
        in_valid = 1'b1;
        op = 4'b0010;
        rs = 32'h1;
        rt = 32'h2;
        #2;
        rst_n = 1'b0;
        #1;
        clear_model();
        check_all("rst_async");
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_all("rst_release");
        step("post_rst", 1'b1, 4'b0000, 32'hFFFF_0000, 32'h0F0F_0F0F);

        for (int i = 0; i < 200; i++) begin
            rop = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : ops[$urandom_range(0, 4)];
            step("rand", ($urandom_range(0, 4) != 0), rop, $urandom, $urandom);
        end
        step("rand_add_big", 1'b1, 4'b0010, 32'h8000_0000, 32'h8000_0000);
        step("rand_neg", 1'b1, 4'b0010, 32'h8000_0000, 32'hFFFF_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
